// File: rtl/viking_vout.sv
// Viking/SM194 video output stage: 2-cycle pixel/sync pipeline plus line/frame measurement.
// Optional 2:1 horizontal decimation is enabled by defining VIKING_HALF_EN.
module viking_vout #(
    parameter logic [23:0] FG_RGB = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB = 24'h000000,
    parameter int unsigned CNT_W  = 12
) (
    input  logic             pclk,
    input  logic             reset_n,
    input  logic             pix,
    input  logic             hs_in,
    input  logic             vs_in,
    input  logic             hblank_in,
    input  logic             vblank_in,
    input  logic             invert,
    input  logic             hs_pol,
    input  logic             vs_pol,
    output logic [7:0]       r,
    output logic [7:0]       g,
    output logic [7:0]       b,
    output logic             hs_out,
    output logic             vs_out,
    output logic             hblank_out,
    output logic             vblank_out,
    output logic             de,
    output logic             ce_pix,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] v_total,
    output logic             frame_ok
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_LOCKED} state_t;

    logic s1_pix, s1_hs, s1_vs, s1_hb, s1_vb, s1_inv, s1_hs_pol, s1_vs_pol;
    logic s1_c, s1_blank;
    logic [23:0] pix_rgb;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            s1_pix    <= 1'b0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            s1_hb     <= 1'b0;
            s1_vb     <= 1'b0;
            s1_inv    <= 1'b0;
            s1_hs_pol <= 1'b0;
            s1_vs_pol <= 1'b0;
        end else begin
            s1_pix    <= pix;
            s1_hs     <= hs_in;
            s1_vs     <= vs_in;
            s1_hb     <= hblank_in;
            s1_vb     <= vblank_in;
            s1_inv    <= invert;
            s1_hs_pol <= hs_pol;
            s1_vs_pol <= vs_pol;
        end
    end

    assign s1_c     = s1_pix ^ s1_inv;
    assign s1_blank = s1_hb | s1_vb;

`ifdef VIKING_HALF_EN
    localparam logic [8:0] SUM_R = 9'(FG_RGB[23:16]) + 9'(BG_RGB[23:16]);
    localparam logic [8:0] SUM_G = 9'(FG_RGB[15:8])  + 9'(BG_RGB[15:8]);
    localparam logic [8:0] SUM_B = 9'(FG_RGB[7:0])   + 9'(BG_RGB[7:0]);
    localparam logic [23:0] MID_RGB = {SUM_R[8:1], SUM_G[8:1], SUM_B[8:1]};

    logic ph1, prev_c;

    // ph1 travels with stage 1: 0 on the first active pixel of a line, 1 on its partner
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            ph1    <= 1'b0;
            prev_c <= 1'b0;
        end else begin
            ph1    <= s1_hb ? 1'b0 : ~ph1;
            prev_c <= s1_c;
        end
    end
`endif

    always_comb begin
        pix_rgb = s1_c ? FG_RGB : BG_RGB;
`ifdef VIKING_HALF_EN
        if (ph1) begin
            if (s1_c && prev_c)
                pix_rgb = FG_RGB;
            else if (!s1_c && !prev_c)
                pix_rgb = BG_RGB;
            else
                pix_rgb = MID_RGB;
        end
`endif
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            r          <= '0;
            g          <= '0;
            b          <= '0;
            hs_out     <= 1'b0;
            vs_out     <= 1'b0;
            hblank_out <= 1'b0;
            vblank_out <= 1'b0;
            de         <= 1'b0;
            ce_pix     <= 1'b0;
        end else begin
            r          <= s1_blank ? '0 : pix_rgb[23:16];
            g          <= s1_blank ? '0 : pix_rgb[15:8];
            b          <= s1_blank ? '0 : pix_rgb[7:0];
            hs_out     <= s1_hs ^ s1_hs_pol;
            vs_out     <= s1_vs ^ s1_vs_pol;
            hblank_out <= s1_hb;
            vblank_out <= s1_vb;
            de         <= ~s1_blank;
`ifdef VIKING_HALF_EN
            ce_pix     <= ph1;
`else
            ce_pix     <= 1'b1;
`endif
        end
    end

    logic hs_d, vs_d, hs_rise, vs_rise;
    logic h_seen, v_seen, sat, pair_ok;
    logic [CNT_W-1:0] hcnt, vcnt, hcnt_nxt, vcnt_nxt, h_total_nxt, v_total_nxt;
    logic [CNT_W-1:0] lat_h, lat_v;
    state_t state;

    assign hs_rise = s1_hs & ~hs_d;
    assign vs_rise = s1_vs & ~vs_d;
    assign sat     = (hcnt == CNT_MAX) || (vcnt == CNT_MAX);

    always_comb begin
        h_total_nxt = h_total;
        if (hs_rise && h_seen)
            h_total_nxt = (hcnt == CNT_MAX) ? CNT_MAX : hcnt + 1'b1;

        v_total_nxt = v_total;
        if (vs_rise && v_seen)
            v_total_nxt = vcnt;

        hcnt_nxt = (hcnt == CNT_MAX) ? CNT_MAX : hcnt + 1'b1;
        if (hs_rise)
            hcnt_nxt = '0;

        // an hs edge coincident with vs belongs to the frame that vs starts
        vcnt_nxt = vcnt;
        if (vs_rise)
            vcnt_nxt = hs_rise ? CNT_W'(1) : '0;
        else if (hs_rise && vcnt != CNT_MAX)
            vcnt_nxt = vcnt + 1'b1;

        pair_ok = (h_total_nxt == lat_h) && (v_total_nxt == lat_v) &&
                  (h_total_nxt != CNT_MAX) && (v_total_nxt != CNT_MAX) && !sat;
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            hs_d    <= 1'b0;
            vs_d    <= 1'b0;
            hcnt    <= '0;
            vcnt    <= '0;
            h_total <= '0;
            v_total <= '0;
            h_seen  <= 1'b0;
            v_seen  <= 1'b0;
        end else begin
            hs_d    <= s1_hs;
            vs_d    <= s1_vs;
            hcnt    <= hcnt_nxt;
            vcnt    <= vcnt_nxt;
            h_total <= h_total_nxt;
            v_total <= v_total_nxt;
            if (hs_rise)
                h_seen <= 1'b1;
            if (vs_rise)
                v_seen <= 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            frame_ok <= 1'b0;
            lat_h    <= '0;
            lat_v    <= '0;
        end else if (vs_rise) begin
            lat_h <= h_total_nxt;
            lat_v <= v_total_nxt;
            if (state != ST_IDLE && pair_ok) begin
                state    <= ST_LOCKED;
                frame_ok <= 1'b1;
            end else begin
                state    <= ST_ARMED;
                frame_ok <= 1'b0;
            end
        end else if (sat && state == ST_LOCKED) begin
            state    <= ST_ARMED;
            frame_ok <= 1'b0;
        end
    end

endmodule
